mux2_rr_arbiter: RTL
====================

# mux2_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready channel between two requesters, A and B. It owns the select line of a DATA_W-wide 2:1 NAND-gate mux datapath and holds each grant for a packet, or a bounded burst of beats, before handing over. It sits between two producer blocks and one consumer, and is the sole driver of the mux select.

## Interface
Parameters:
- DATA_W, 8, width of the data buses.
- MAX_BURST, 4, maximum beats per grant. Must be ≥1. The value 1 forces per-beat alternation under contention.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  requester A beat valid.
- a_data  in  DATA_W  requester A data.
- a_last  in  1  requester A final beat of packet.
- a_ready  out  1  requester A beat accepted.
- b_valid, b_data, b_last, b_ready  same as A, for requester B.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_W  downstream data, equal to the mux output.
- out_last  out  1  downstream last flag.
- out_ready  in  1  downstream accepts beat.
- sel  out  1  mux select. 1 routes A, 0 routes B.
- busy  out  1  a grant is active.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_A: sel=1.
  - GRANT_B: sel=0.
- Priority pointer `last_win` records the requester granted most recently. Reset value is B, so A wins the first tie.
- Arbitration from IDLE, or at a release:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not `last_win`.
  - If neither is valid, go to IDLE.
- Datapath while in GRANT_X:
  - out_data = mux output.
  - out_valid = X_valid.
  - out_last = X_last.
  - X_ready = out_ready.
  - The other requester's ready = 0.
- In IDLE: out_valid=0, a_ready=0, b_ready=0, and sel holds its last value.
- A beat transfers when out_valid && out_ready.
- burst_cnt counts beats transferred in the current grant. Width is $clog2(MAX_BURST+1).
- Release occurs on the transfer beat where X_last=1, or where burst_cnt+1 == MAX_BURST. On that edge:
  - burst_cnt clears to 0.
  - last_win takes the value X.
  - Arbitration runs on the valids sampled that cycle, which allows a direct GRANT_A→GRANT_B handoff.
- The grant is never dropped mid-burst. While granted, X_valid may deassert and the grant holds.
- Requesters hold valid, data and last stable until ready. The arbiter does not check this.
- Reset values:
  - state=IDLE, sel=1, busy=0, out_valid=0, a_ready=0, b_ready=0, out_last=0.
  - burst_cnt=0, last_win=B.
- Assertion of rst_n=0 mid-burst clears all state immediately (asynchronous). Beats in flight are lost, and requesters must re-present them.

## Timing
- Arbitration latency is 1 cycle: a valid seen in IDLE produces the grant and sel on the next edge. The first beat can transfer in that next cycle.
- A handoff at release has no bubble. The new grantee's beat can transfer in the cycle immediately after the release beat.
- Within a grant, throughput is 1 beat per cycle when out_ready=1.
- The data path is combinational through the gate-level mux with no register. sel is registered, so the mux settles after the clock edge and must meet the cycle budget.
- out_valid, out_last and the ready outputs are combinational functions of the registered state and the inputs.

## Structure
- Package `mux_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t`.
  - `typedef enum logic {REQ_B=0, REQ_A=1} req_id_t`, whose encoding matches sel.
- Sub-module `mux2to1_bus #(DATA_W)`: a generate loop of per-bit `mux2to1_slice` instances, driven by sel.
- The arbiter holds the FSM, the pointer, the burst counter and the ready/valid steering.

## Test plan
- Reset, then a_valid=1, a_data=8'h3C, a_last=1, out_ready=1. Required: grant on cycle 1, sel=1, out_data=8'h3C, a_ready=1, then return to IDLE with last_win=A.
- Both valid from reset, every beat last=1. Required: grant order A,B,A,B with no idle cycle between handoffs.
- MAX_BURST=4, A streams 10 beats with no last, B valid throughout. Required: A gets 4 beats, B gets its packet, A gets 4 more.
- Only A valid with an 8-beat packet, MAX_BURST=4. Required: release after beat 4 and re-grant to A with no bubble; B's ready stays 0.
- out_ready toggles 1,0,1 mid-burst. Required: burst_cnt advances only on transfer beats, and sel is stable throughout.
- rst_n pulsed low mid-burst on B. Required: outputs take reset values immediately, and the next tie goes to A.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and the arbitration decision for mux2_rr_arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT_A, GRANT_B)
//   req_id_t    : requester identity; encoding equals the mux select value
//   arb_pick()  : round-robin choice between two requests given the
//                 requester that won most recently
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // REQ_A = 1 so a req_id_t can be used directly as the mux select.
    typedef enum logic {
        REQ_B = 1'b0,
        REQ_A = 1'b1
    } req_id_t;

    // A tie goes to whichever requester did not win last time.
    function automatic arb_state_t arb_pick(input logic    req_a,
                                            input logic    req_b,
                                            input req_id_t last_win);
        arb_state_t pick;
        if (req_a && req_b) begin
            pick = (last_win == REQ_A) ? GRANT_B : GRANT_A;
        end else if (req_a) begin
            pick = GRANT_A;
        end else if (req_b) begin
            pick = GRANT_B;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux2to1_bus.sv
// ---------------------------------------------------------------------------
// mux2to1_bus
// DATA_W-wide 2:1 mux made of per-bit NAND slices sharing one select.
//   in_a  [DATA_W] : routed to out when sel = 1
//   in_b  [DATA_W] : routed to out when sel = 0
//   sel            : select
//   out   [DATA_W] : mux output (purely combinational)
// ---------------------------------------------------------------------------
module mux2to1_bus #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              sel,
    output logic [DATA_W-1:0] out
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        mux2to1_slice u_slice (
            .in_a  (in_a[i]),
            .in_b  (in_b[i]),
            .sel   (sel),
            .out_y (out[i])
        );
    end

endmodule

// File: rtl/mux2to1_slice.sv
// ---------------------------------------------------------------------------
// mux2to1_slice
// One bit of the 2:1 datapath mux, built from NAND gates only.
//   in_a  : selected when sel = 1
//   in_b  : selected when sel = 0
//   sel   : select
//   out_y : mux output
// ---------------------------------------------------------------------------
module mux2to1_slice (
    input  logic in_a,
    input  logic in_b,
    input  logic sel,
    output logic out_y
);

    logic sel_n;
    logic nand_a;
    logic nand_b;

    assign sel_n  = ~(sel & sel);
    assign nand_a = ~(in_a & sel);
    assign nand_b = ~(in_b & sel_n);
    assign out_y  = ~(nand_a & nand_b);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
// Round-robin arbiter sharing one downstream valid/ready channel between
// requesters A and B. It drives the select of a NAND-gate 2:1 data mux and
// holds each grant until a last beat or MAX_BURST beats have transferred.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a_valid/a_data/a_last/a_ready : requester A channel
//   b_valid/b_data/b_last/b_ready : requester B channel
//   out_valid/out_data/out_last/out_ready : downstream channel
//   sel                         : mux select, 1 = A, 0 = B (registered)
//   busy                        : a grant is active
//
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. The sender holds valid, data and last stable until it sees ready;
// ready may depend combinationally on valid-independent state only, and
// valid never waits for ready.
// ---------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(MAX_BURST + 1);
    // burst_cnt value on the beat that exhausts the burst allowance.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q,     state_d;
    req_id_t          last_win_q,  last_win_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             sel_q,       sel_d;

    logic xfer;
    logic release_now;
    logic req_a;
    logic req_b;

    always_comb begin
        state_d     = state_q;
        last_win_d  = last_win_q;
        burst_cnt_d = burst_cnt_q;
        sel_d       = sel_q;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        xfer        = 1'b0;
        release_now = 1'b0;
        req_a       = 1'b0;
        req_b       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = arb_pick(a_valid, b_valid, last_win_q);
            end
            GRANT_A: begin
                out_valid = a_valid;
                out_last  = a_last;
                a_ready   = out_ready;
            end
            GRANT_B: begin
                out_valid = b_valid;
                out_last  = b_last;
                b_ready   = out_ready;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        xfer        = out_valid && out_ready;
        release_now = xfer && (out_last || (burst_cnt_q == CNT_LAST));

        if (release_now) begin
            burst_cnt_d = '0;
            last_win_d  = (state_q == GRANT_A) ? REQ_A : REQ_B;
            // The grantee's valid this cycle belongs to the beat being
            // consumed. It only signals more pending data when that beat
            // did not close the packet (i.e. a burst-limit release).
            req_a   = a_valid && !((state_q == GRANT_A) && a_last);
            req_b   = b_valid && !((state_q == GRANT_B) && b_last);
            state_d = arb_pick(req_a, req_b, last_win_d);
        end else if (xfer) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end

        // sel follows every new grant and holds its value through IDLE.
        case (state_d)
            GRANT_A: sel_d = 1'b1;
            GRANT_B: sel_d = 1'b0;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_win_q  <= REQ_B;
            burst_cnt_q <= '0;
            sel_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_win_q  <= last_win_d;
            burst_cnt_q <= burst_cnt_d;
            sel_q       <= sel_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);

    mux2to1_bus #(
        .DATA_W (DATA_W)
    ) u_mux (
        .in_a (a_data),
        .in_b (b_data),
        .sel  (sel_q),
        .out  (out_data)
    );

endmodule
